// File: rtl/maquina_pkg.sv
// Shared definitions for the Maquina Sencilla control path: FSM states,
// opcode fields, address-mux selects and ALU operation codes.
package maquina_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD_B,
        S_EXEC,
        S_IO,
        S_HALT
    } state_e;

    // ALU-class instructions are identified by cop[3:2]; the rest use all four bits
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [1:0] OP_EXT  = 2'b11;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_IN   = 4'b1101;
    localparam logic [3:0] OP_OUT  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_ZERO = 2'b01;
    localparam logic [1:0] SEL_SRC  = 2'b10;
    localparam logic [1:0] SEL_DST  = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

endpackage

// File: rtl/io_watchdog.sv
// Saturating 16-bit cycle counter guarding the I/O handshake; flags a timeout
// on the cycle that would be the IO_TIMEOUT-th consecutive non-ack cycle.
module io_watchdog #(
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != '1) begin
            count <= count + 16'd1;
        end
    end

    // count holds the number of prior non-ack cycles, so the current one is count+1
    assign timeout = (count >= 16'(IO_TIMEOUT - 1));

endmodule

// File: rtl/control_unit.sv
// Four-phase fetch/decode/execute sequencer for the Maquina Sencilla datapath,
// with a req/ack port handshake for IN/OUT guarded by io_watchdog.
module control_unit
    import maquina_pkg::*;
#(
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cop,
    input  logic       fz,
    input  logic       port_ack,
    output logic       mx1,
    output logic       mx0,
    output logic       alu_op1,
    output logic       alu_op0,
    output logic       le,
    output logic       pc_w,
    output logic       ir_w,
    output logic       a_w,
    output logic       b_w,
    output logic       fz_w,
    output logic       mx_memio,
    output logic       port_rd,
    output logic       port_wr,
    output logic       io_err,
    output logic       halted
);

    state_e     state, state_next;
    logic [1:0] mx, alu_op;
    logic       wd_clear, wd_en, wd_timeout, err_set;

    io_watchdog #(.IO_TIMEOUT(IO_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_en),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            io_err <= 1'b0;
        end else begin
            state <= state_next;
            if (err_set) io_err <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        mx         = SEL_PC;
        alu_op     = ALU_ADD;
        le         = 1'b0;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        a_w        = 1'b0;
        b_w        = 1'b0;
        fz_w       = 1'b0;
        mx_memio   = 1'b0;
        port_rd    = 1'b0;
        port_wr    = 1'b0;
        halted     = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;
        err_set    = 1'b0;

        case (state)
            S_FETCH: begin
                mx         = SEL_PC;
                ir_w       = 1'b1;
                pc_w       = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (cop[3:2] != OP_EXT) begin
                    mx         = SEL_SRC;
                    a_w        = 1'b1;
                    state_next = (cop[3:2] == OP_MOV) ? S_EXEC : S_LOAD_B;
                end else begin
                    case (cop)
                        OP_BEQ: begin
                            // taken branch loads pc and ir from the target in one go
                            if (fz) begin
                                mx         = SEL_DST;
                                ir_w       = 1'b1;
                                pc_w       = 1'b1;
                                state_next = S_DECODE;
                            end else begin
                                state_next = S_FETCH;
                            end
                        end
                        OP_IN, OP_OUT: begin
                            wd_clear   = 1'b1;
                            state_next = S_IO;
                        end
                        default: state_next = S_HALT;
                    endcase
                end
            end
            S_LOAD_B: begin
                mx         = SEL_DST;
                b_w        = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                mx   = SEL_DST;
                fz_w = 1'b1;
                case (cop[3:2])
                    OP_ADD: begin
                        alu_op = ALU_ADD;
                        le     = 1'b1;
                    end
                    OP_CMP: alu_op = ALU_SUB;
                    default: begin
                        alu_op = ALU_PASS;
                        le     = 1'b1;
                    end
                endcase
                state_next = S_FETCH;
            end
            S_IO: begin
                mx      = SEL_DST;
                port_rd = (cop == OP_IN);
                port_wr = (cop == OP_OUT);
                if (port_ack) begin
                    le         = port_rd;
                    mx_memio   = port_rd;
                    state_next = S_FETCH;
                end else if (wd_timeout) begin
                    err_set    = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    wd_en = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_FETCH;
        endcase

        // outputs are forced quiet for the whole reset interval, including mid-IO
        if (!rst_n) begin
            mx       = SEL_PC;
            alu_op   = ALU_ADD;
            le       = 1'b0;
            pc_w     = 1'b0;
            ir_w     = 1'b0;
            a_w      = 1'b0;
            b_w      = 1'b0;
            fz_w     = 1'b0;
            mx_memio = 1'b0;
            port_rd  = 1'b0;
            port_wr  = 1'b0;
            halted   = 1'b0;
        end
    end

    assign mx1     = mx[1];
    assign mx0     = mx[0];
    assign alu_op1 = alu_op[1];
    assign alu_op0 = alu_op[0];

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model expands each
// instruction into its expected per-cycle output trace, checked every cycle.
module tb_control_unit;

    localparam int TO = 4;

    typedef struct packed {
        logic [1:0] mx;
        logic [1:0] alu;
        logic       le, pc_w, ir_w, a_w, b_w, fz_w, mx_memio;
        logic       port_rd, port_wr, io_err, halted;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cop;
    logic       fz, port_ack;
    logic       mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w;
    logic       mx_memio, port_rd, port_wr, io_err, halted;
    outs_t      dut_o;

    control_unit #(.IO_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cop(cop), .fz(fz), .port_ack(port_ack),
        .mx1(mx1), .mx0(mx0), .alu_op1(alu_op1), .alu_op0(alu_op0), .le(le),
        .pc_w(pc_w), .ir_w(ir_w), .a_w(a_w), .b_w(b_w), .fz_w(fz_w),
        .mx_memio(mx_memio), .port_rd(port_rd), .port_wr(port_wr),
        .io_err(io_err), .halted(halted)
    );

    assign dut_o = {mx1, mx0, alu_op1, alu_op0, le, pc_w, ir_w, a_w, b_w, fz_w,
                    mx_memio, port_rd, port_wr, io_err, halted};

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc_cnt  = 0;
    int    rd_cnt = 0, wr_cnt = 0, le_cnt = 0;
    outs_t exp_q[$];
    logic  err_m = 1'b0;
    bit    skip_fetch_m = 1'b0;
    logic [3:0] cur_cop = 4'd0;
    logic       cur_fz = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // one cycle of stimulus; expected outputs are queued for the compare process
    task automatic step(input outs_t e, input logic ack);
        cop      = cur_cop;
        fz       = cur_fz;
        port_ack = ack;
        e.io_err = err_m;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc_cnt++;
    endtask

    // instruction-level model: ack_at is the IO cycle index of ack (-1 = never)
    task automatic run_instr(input logic [3:0] c, input logic f, input int ack_at,
                             input logic noise, output int ncyc);
        outs_t e;
        int    start;
        start   = cyc_cnt;
        cur_cop = c;
        cur_fz  = f;
        if (!skip_fetch_m) begin
            e = '0; e.mx = 2'b00; e.ir_w = 1'b1; e.pc_w = 1'b1;
            step(e, noise);
        end
        skip_fetch_m = 1'b0;
        if (c == 4'b0000 || c[3:2] == 2'b00 || c[3:2] == 2'b01 || c[3:2] == 2'b10) begin
            e = '0; e.mx = 2'b10; e.a_w = 1'b1;
            step(e, noise);
            if (c[3:2] != 2'b10) begin
                e = '0; e.mx = 2'b11; e.b_w = 1'b1;
                step(e, noise);
            end
            e = '0; e.mx = 2'b11; e.fz_w = 1'b1;
            case (c[3:2])
                2'b00:   begin e.alu = 2'b00; e.le = 1'b1; end
                2'b01:   begin e.alu = 2'b01; e.le = 1'b0; end
                default: begin e.alu = 2'b10; e.le = 1'b1; end
            endcase
            step(e, noise);
        end else if (c == 4'b1100) begin
            e = '0;
            if (f) begin
                e.mx = 2'b11; e.ir_w = 1'b1; e.pc_w = 1'b1;
                skip_fetch_m = 1'b1;
            end
            step(e, noise);
        end else if (c == 4'b1101 || c == 4'b1110) begin
            e = '0;
            step(e, noise);
            for (int i = 0; ; i++) begin
                e = '0; e.mx = 2'b11;
                e.port_rd = (c == 4'b1101);
                e.port_wr = (c == 4'b1110);
                if (i == ack_at) begin
                    e.le = e.port_rd; e.mx_memio = e.port_rd;
                    step(e, 1'b1);
                    break;
                end
                step(e, 1'b0);
                if (i + 1 == TO) begin
                    err_m = 1'b1;
                    break;
                end
            end
        end else begin
            e = '0;
            step(e, noise);
            for (int i = 0; i < 6; i++) begin
                e = '0; e.halted = 1'b1;
                step(e, noise);
            end
        end
        port_ack = 1'b0;
        ncyc = cyc_cnt - start;
    endtask

    initial begin : compare
        outs_t ex;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                ex = exp_q.pop_front();
                check("cycle_outputs", 32'(dut_o), 32'(ex));
                if (dut_o.port_rd) rd_cnt++;
                if (dut_o.port_wr) wr_cnt++;
                if (dut_o.le) le_cnt++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL bench_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int    n;
        outs_t e;
        rst_n = 1'b0; cop = 4'b0000; fz = 1'b0; port_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs_zero", 32'(dut_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(4'b0000, 1'b0, -1, 1'b1, n); check("add_cycles", n, 4);
        run_instr(4'b0100, 1'b1, -1, 1'b0, n); check("cmp_cycles", n, 4);
        run_instr(4'b1000, 1'b0, -1, 1'b0, n); check("mov_cycles", n, 3);
        run_instr(4'b1100, 1'b0, -1, 1'b0, n); check("beq_nt_cycles", n, 2);
        run_instr(4'b1100, 1'b1, -1, 1'b0, n); check("beq_t_cycles", n, 2);
        run_instr(4'b0011, 1'b0, -1, 1'b0, n); check("add_after_branch_cycles", n, 3);

        rd_cnt = 0; le_cnt = 0;
        run_instr(4'b1101, 1'b0, 3, 1'b0, n);
        check("in_cycles", n, 6);
        check("in_rd_cycles", rd_cnt, 4);
        check("in_le_cycles", le_cnt, 1);

        wr_cnt = 0; le_cnt = 0;
        run_instr(4'b1110, 1'b0, TO - 1, 1'b0, n);
        check("out_ack_at_limit_wr", wr_cnt, 4);
        #1 check("out_ack_at_limit_ioerr", 32'(io_err), 0);
        run_instr(4'b1110, 1'b0, 0, 1'b0, n); check("out_fast_cycles", n, 3);

        wr_cnt = 0; le_cnt = 0;
        run_instr(4'b1110, 1'b0, -1, 1'b0, n);
        check("out_timeout_wr", wr_cnt, 4);
        check("out_timeout_le", le_cnt, 0);
        #1 check("out_timeout_ioerr", 32'(io_err), 1);
        run_instr(4'b0001, 1'b0, -1, 1'b0, n);
        run_instr(4'b1101, 1'b0, 1, 1'b0, n);

        // IN interrupted by reset in the middle of its handshake
        cur_cop = 4'b1101; cur_fz = 1'b0;
        e = '0; e.ir_w = 1'b1; e.pc_w = 1'b1; step(e, 1'b0);
        e = '0; step(e, 1'b0);
        e = '0; e.mx = 2'b11; e.port_rd = 1'b1; step(e, 1'b0); step(e, 1'b0);
        #3 rst_n = 1'b0;
        #1 check("reset_mid_in_port_rd", 32'(port_rd), 0);
        check("reset_mid_in_outputs", 32'(dut_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; err_m = 1'b0; skip_fetch_m = 1'b0;
        run_instr(4'b0000, 1'b0, -1, 1'b0, n); check("add_after_reset_cycles", n, 4);
        run_instr(4'b1010, 1'b1, -1, 1'b0, n);

        run_instr(4'b1111, 1'b0, -1, 1'b1, n);
        #1 check("halt_flag", 32'(halted), 1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
